gen_line_rdadd: RTL and testbench
=================================

GEN_LINE_RDADD -- requirements
Module: gen_line_rdadd

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent line-buffer read channels (range 1-8).
REQ-002 The block SHALL have parameter ADDR_W, default 11, giving the read-address width per channel.
REQ-003 The block SHALL have parameter MAX_COLS, default 1280, giving the maximum and reset column count, with MAX_COLS <= 2^ADDR_W.
REQ-004 The block SHALL have parameter ROWS, default 1024, giving the number of lines per frame.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port aclr, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port rden, input, NUM_CH bits: per-channel read enable; bit k advances channel k.
REQ-008 The block SHALL have port cfg_load, input, 1 bit: a single-cycle strobe that loads col_size and restarts all counters.
REQ-009 The block SHALL have port col_size, input, ADDR_W bits: the runtime line length, sampled only on cfg_load.
REQ-010 The block SHALL have port rdadd, output, NUM_CH*ADDR_W bits: packed per-channel read addresses, with channel k at bits [k*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port line_end, output, NUM_CH bits: a per-channel one-cycle wrap pulse.
REQ-012 The block SHALL have port rot_sel, output, 3 bits: the index of the oldest line buffer, modulo NUM_CH.
REQ-013 The block SHALL have port row_cnt, output, 11 bits: the current row index.
REQ-014 The block SHALL have port frame_done, output, 1 bit: a one-cycle end-of-frame pulse.

Function
REQ-015 The block SHALL hold an internal col_lim register; on cfg_load, col_lim SHALL take col_size, except that col_size = 0 or col_size > MAX_COLS SHALL load MAX_COLS.
REQ-016 On cfg_load, the block SHALL clear every rdadd channel, rot_sel and row_cnt to 0 and hold line_end and frame_done at 0 in the following cycle.
REQ-017 The block SHALL give cfg_load priority over rden on the same cycle, so rden is ignored in that cycle.
REQ-018 Channel k, with rden[k]=1 and rdadd_k < col_lim-1, SHALL increment rdadd_k by 1 on the next edge.
REQ-019 Channel k, with rden[k]=1 and rdadd_k = col_lim-1, SHALL reload rdadd_k to 0 on the next edge and drive line_end[k]=1 for exactly that one cycle.
REQ-020 Channel k with rden[k]=0 SHALL hold rdadd_k and drive line_end[k]=0.
REQ-021 Channels SHALL be fully independent; any rden combination, including all channels set at once, SHALL advance each enabled channel with no interaction between channels.
REQ-022 Every channel 0 wrap SHALL advance rot_sel by 1, and rot_sel SHALL wrap from NUM_CH-1 to 0; with NUM_CH = 1, rot_sel SHALL stay at 0.
REQ-023 Every channel 0 wrap SHALL increment row_cnt; a wrap with row_cnt = ROWS-1 SHALL instead load row_cnt = 0 and drive frame_done=1 for that one cycle.
REQ-024 All outputs SHALL be registered with no combinational input-to-output paths, and address latency from rden SHALL be exactly 1 cycle.
REQ-025 With col_lim = 1, an enabled channel SHALL hold rdadd = 0 and pulse line_end on every enabled cycle.

Reset
REQ-026 With aclr=1, the block SHALL immediately drive rdadd = 0, line_end = 0, rot_sel = 0, row_cnt = 0 and frame_done = 0, and set col_lim to MAX_COLS, independent of clk.
REQ-027 An aclr asserted mid-line or mid-frame SHALL abandon all progress, so the first enabled edge after release produces rdadd = 1 with no line_end.
REQ-028 The block SHALL ignore rden and cfg_load for as long as aclr=1.

Configuration
REQ-029 Macro GEN_LINE_RDADD_ROWCNT_EN, when defined, SHALL compile in the row counter and frame_done logic of REQ-023.
REQ-030 With GEN_LINE_RDADD_ROWCNT_EN undefined, row_cnt SHALL be constant 0, frame_done SHALL be constant 0, no row register SHALL be synthesised, and all other behaviour SHALL be unchanged.

Verification
REQ-031 The bench SHALL cover: reset, then rden=2'b01 held for 1281 cycles with defaults -> ch0 counts 0..1279 then 0, line_end[0] high one cycle, rot_sel = 1, ch1 stays 0.
REQ-032 The bench SHALL cover: cfg_load with col_size = 12, then rden=2'b11 for 24 cycles -> both channels wrap twice, line_end = 2'b11 on cycles 12 and 24, rot_sel returns to 0.
REQ-033 The bench SHALL cover: cfg_load with col_size = 0, and separately with col_size = 2000 -> col_lim = 1280 in both cases, verified by wrap at 1279.
REQ-034 The bench SHALL cover: cfg_load and rden=1 on the same edge with rdadd = 5 -> rdadd = 0 next cycle, no line_end.
REQ-035 The bench SHALL cover, with ROWCNT_EN defined, ROWS = 4 and col_size = 3: 12 enabled ch0 cycles -> row_cnt 1,2,3,0 and frame_done one cycle coincident with the fourth line_end[0]; with ROWCNT_EN undefined -> row_cnt and frame_done stay 0.
REQ-036 The bench SHALL cover: aclr pulsed asynchronously between edges with rdadd = 7 -> outputs 0 before the next edge, col_lim = 1280 afterwards.

Source files
------------

// File: rtl/gen_line_rdadd.sv
// rtl/gen_line_rdadd.sv - multi-channel line-buffer read address generator
//
// Generates independent per-channel column read addresses for a set of line
// buffers, a rotating oldest-buffer index, and (optionally) a row counter with
// an end-of-frame pulse.
//
// Optional feature macro: GEN_LINE_RDADD_ROWCNT_EN
//    defined   : row_cnt / frame_done are live
//    undefined : row_cnt and frame_done are tied to 0, no row register exists
//
// Ports:
//    clk        in   rising-edge clock
//    aclr       in   asynchronous active-high reset
//    rden       in   [NUM_CH]         per-channel read enable
//    cfg_load   in   1-cycle strobe: load col_size, restart all counters
//    col_size   in   [ADDR_W]         runtime line length (0 or >MAX_COLS -> MAX_COLS)
//    rdadd      out  [NUM_CH*ADDR_W]  channel k at [k*ADDR_W +: ADDR_W]
//    line_end   out  [NUM_CH]         per-channel wrap pulse
//    rot_sel    out  [3]              oldest line buffer index, modulo NUM_CH
//    row_cnt    out  [11]             current row
//    frame_done out  1-cycle end-of-frame pulse

module gen_line_rdadd #(
   parameter int NUM_CH   = 2,
   parameter int ADDR_W   = 11,
   parameter int MAX_COLS = 1280,
   parameter int ROWS     = 1024
) (
   input  logic                       clk,
   input  logic                       aclr,
   input  logic [NUM_CH-1:0]          rden,
   input  logic                       cfg_load,
   input  logic [ADDR_W-1:0]          col_size,
   output logic [NUM_CH*ADDR_W-1:0]   rdadd,
   output logic [NUM_CH-1:0]          line_end,
   output logic [2:0]                 rot_sel,
   output logic [10:0]                row_cnt,
   output logic                       frame_done
);

   if (NUM_CH < 1 || NUM_CH > 8 || ROWS < 1 || MAX_COLS < 1 ||
       MAX_COLS > (1 << ADDR_W)) begin : g_bad_param
      $error("gen_line_rdadd: illegal parameter combination");
   end

   // The last column index is stored rather than the column count, so that
   // MAX_COLS = 2^ADDR_W still fits in ADDR_W bits.
   localparam logic [ADDR_W:0]   MAX_EXT  = (ADDR_W+1)'(MAX_COLS);
   localparam logic [ADDR_W-1:0] MAX_LAST = ADDR_W'(MAX_COLS - 1);
   localparam logic [2:0]        ROT_LAST = 3'(NUM_CH - 1);

   logic [ADDR_W-1:0] col_last;
   logic [ADDR_W-1:0] load_last;
   logic [ADDR_W:0]   size_ext;
   logic [NUM_CH-1:0] wrap;

   assign size_ext = {1'b0, col_size};

   always_comb begin
      load_last = col_size - ADDR_W'(1);
      if (col_size == '0 || size_ext > MAX_EXT)
         load_last = MAX_LAST;
   end

   always_comb begin
      wrap = '0;
      for (int k = 0; k < NUM_CH; k++)
         wrap[k] = rden[k] && (rdadd[k*ADDR_W +: ADDR_W] == col_last);
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         col_last <= MAX_LAST;
         rdadd    <= '0;
         line_end <= '0;
         rot_sel  <= '0;
      end else if (cfg_load) begin
         col_last <= load_last;
         rdadd    <= '0;
         line_end <= '0;
         rot_sel  <= '0;
      end else begin
         line_end <= wrap;
         for (int k = 0; k < NUM_CH; k++) begin
            if (rden[k])
               rdadd[k*ADDR_W +: ADDR_W] <= wrap[k] ? '0
                                          : rdadd[k*ADDR_W +: ADDR_W] + ADDR_W'(1);
         end
         // With NUM_CH = 1, ROT_LAST is 0 and rot_sel never leaves 0.
         if (wrap[0])
            rot_sel <= (rot_sel == ROT_LAST) ? 3'd0 : rot_sel + 3'd1;
      end
   end

`ifdef GEN_LINE_RDADD_ROWCNT_EN
   localparam logic [10:0] ROW_LAST = 11'(ROWS - 1);

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         row_cnt    <= '0;
         frame_done <= 1'b0;
      end else if (cfg_load) begin
         row_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (wrap[0]) begin
            if (row_cnt == ROW_LAST) begin
               row_cnt    <= '0;
               frame_done <= 1'b1;
            end else begin
               row_cnt <= row_cnt + 11'd1;
            end
         end
      end
   end
`else
   assign row_cnt    = '0;
   assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_gen_line_rdadd.sv
// tb/tb_gen_line_rdadd.sv - directed self-checking bench for gen_line_rdadd
module tb_gen_line_rdadd;

   localparam int NUM_CH = 2;
   localparam int ADDR_W = 11;
   localparam int ROWS   = 4;
`ifdef GEN_LINE_RDADD_ROWCNT_EN
   localparam bit ROWEN = 1'b1;
`else
   localparam bit ROWEN = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     aclr = 1'b1;
   logic [NUM_CH-1:0]        rden = '0;
   logic                     cfg_load = 1'b0;
   logic [ADDR_W-1:0]        col_size = '0;
   logic [NUM_CH*ADDR_W-1:0] rdadd;
   logic [NUM_CH-1:0]        line_end;
   logic [2:0]               rot_sel;
   logic [10:0]              row_cnt;
   logic                     frame_done;

   int errors = 0;
   int checks = 0;

   // expected-state model
   int m_addr [NUM_CH];
   int m_lim;
   int m_le;
   int m_rot;
   int m_row;
   int m_fd;

   gen_line_rdadd #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MAX_COLS(1280), .ROWS(ROWS)) dut (
      .clk(clk), .aclr(aclr), .rden(rden), .cfg_load(cfg_load), .col_size(col_size),
      .rdadd(rdadd), .line_end(line_end), .rot_sel(rot_sel), .row_cnt(row_cnt),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ch_addr(input int k);
      return 32'(rdadd[k*ADDR_W +: ADDR_W]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) m_addr[k] = 0;
      m_lim = 1280; m_le = 0; m_rot = 0; m_row = 0; m_fd = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_a0"}, ch_addr(0), 32'(m_addr[0]));
      chk({tag, "_a1"}, ch_addr(1), 32'(m_addr[1]));
      chk({tag, "_le"}, 32'(line_end), 32'(m_le));
      chk({tag, "_rot"}, 32'(rot_sel), 32'(m_rot));
      chk({tag, "_row"}, 32'(row_cnt), ROWEN ? 32'(m_row) : 32'd0);
      chk({tag, "_fd"}, 32'(frame_done), ROWEN ? 32'(m_fd) : 32'd0);
   endtask

   // one clock: drive, edge, update model, compare
   task automatic tick(input string tag, input logic [NUM_CH-1:0] rd,
                       input logic cfg, input int sz);
      rden = rd; cfg_load = cfg; col_size = ADDR_W'(sz);
      @(posedge clk); #1;
      rden = '0; cfg_load = 1'b0;
      m_le = 0; m_fd = 0;
      if (cfg) begin
         m_lim = (sz == 0 || sz > 1280) ? 1280 : sz;
         for (int k = 0; k < NUM_CH; k++) m_addr[k] = 0;
         m_rot = 0; m_row = 0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (rd[k]) begin
               if (m_addr[k] == m_lim - 1) begin
                  m_addr[k] = 0;
                  m_le |= (1 << k);
               end else begin
                  m_addr[k]++;
               end
            end
         end
         if (m_le & 1) begin
            m_rot = (m_rot == NUM_CH - 1) ? 0 : m_rot + 1;
            if (m_row == ROWS - 1) begin m_row = 0; m_fd = 1; end
            else m_row++;
         end
      end
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk); aclr = 1'b0;
      @(posedge clk); #1;

      // default limit: ch0 only for 1281 edges
      for (int i = 1; i <= 1281; i++) begin
         tick("def", 2'b01, 1'b0, 0);
         if (i == 1279) chk("def_1279", ch_addr(0), 32'd1279);
         if (i == 1280) begin
            chk("def_wrap_a", ch_addr(0), 32'd0);
            chk("def_wrap_le", 32'(line_end), 32'd1);
         end
      end
      chk("def_rot", 32'(rot_sel), 32'd1);
      chk("def_ch1", ch_addr(1), 32'd0);
      chk("def_row", 32'(row_cnt), ROWEN ? 32'd1 : 32'd0);
      tick("hold", 2'b00, 1'b0, 0);
      chk("hold_a0", ch_addr(0), 32'd1);

      // col_size 12, both channels
      tick("cfg12", 2'b11, 1'b1, 12);
      chk("cfg12_rot", 32'(rot_sel), 32'd0);
      for (int i = 1; i <= 24; i++) begin
         tick("c12", 2'b11, 1'b0, 0);
         if (i == 12 || i == 24) chk("c12_le", 32'(line_end), 32'd3);
         if (i == 12) chk("c12_rot1", 32'(rot_sel), 32'd1);
      end
      chk("c12_rot0", 32'(rot_sel), 32'd0);

      // cfg_load beats rden while ch0 at 5
      for (int i = 0; i < 5; i++) tick("to5", 2'b01, 1'b0, 0);
      chk("pri_pre", ch_addr(0), 32'd5);
      tick("pri", 2'b01, 1'b1, 12);
      chk("pri_a0", ch_addr(0), 32'd0);
      chk("pri_le", 32'(line_end), 32'd0);

      // out-of-range sizes fall back to 1280
      tick("cfg0", 2'b00, 1'b1, 0);
      for (int i = 1; i <= 1280; i++) tick("sz0", 2'b01, 1'b0, 0);
      chk("sz0_le", 32'(line_end), 32'd1);
      tick("cfg2000", 2'b00, 1'b1, 2000);
      for (int i = 1; i <= 1280; i++) tick("sz2000", 2'b01, 1'b0, 0);
      chk("sz2000_le", 32'(line_end), 32'd1);

      // col_size 1: always wraps
      tick("cfg1", 2'b00, 1'b1, 1);
      tick("c1a", 2'b10, 1'b0, 0);
      chk("c1_le", 32'(line_end), 32'd2);
      tick("c1b", 2'b10, 1'b0, 0);
      chk("c1_a1", ch_addr(1), 32'd0);

      // rows: col_size 3, ROWS 4
      tick("cfg3", 2'b00, 1'b1, 3);
      for (int i = 1; i <= 12; i++) begin
         tick("row", 2'b01, 1'b0, 0);
         if (i % 3 == 0)
            chk("row_cnt", 32'(row_cnt), ROWEN ? 32'((i / 3) % 4) : 32'd0);
         if (i == 12) chk("row_fd", 32'(frame_done), ROWEN ? 32'd1 : 32'd0);
      end

      // async reset mid-line with ch0 at 7, cfg_load ignored during reset
      tick("cfg12b", 2'b00, 1'b1, 12);
      for (int i = 0; i < 7; i++) tick("to7", 2'b01, 1'b0, 0);
      chk("ar_pre", ch_addr(0), 32'd7);
      #2 aclr = 1'b1;
      #1;
      model_reset();
      check_all("ar_async");
      rden = 2'b11; cfg_load = 1'b1; col_size = ADDR_W'(3);
      @(posedge clk); #1;
      check_all("ar_held");
      rden = '0; cfg_load = 1'b0;
      aclr = 1'b0;
      tick("ar_first", 2'b01, 1'b0, 0);
      chk("ar_first_a0", ch_addr(0), 32'd1);
      chk("ar_first_le", 32'(line_end), 32'd0);
      for (int i = 2; i <= 1280; i++) tick("ar_run", 2'b01, 1'b0, 0);
      chk("ar_wrap_le", 32'(line_end), 32'd1);
      chk("ar_wrap_a0", ch_addr(0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
